ram_prog_loader: RTL and testbench

Parametrised UART-fed program loader for the on-chip instruction RAM. It consumes received bytes from the UART receiver, frames them into words of configurable width, and issues write strobes to the RAM's programming port. It holds the core in reset until a complete frame passes its checksum, then releases it. It adds length framing, checksum validation, an inter-byte timeout and software-triggered reload.

---
 rtl/ram_prog_loader.sv | 154 +++++++++++++++
 tb/tb_ram_prog_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_prog_loader.sv
// UART-fed program loader: frames received bytes into RAM words, validates a
// trailing checksum and holds the core in reset until a good frame has landed.
module ram_prog_loader #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]        SYNC_BYTE   = 8'h55,
  parameter int unsigned       TIMEOUT_CYC = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              reload_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       words_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum, StRun} state_e;

  state_e            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       wcnt;
  logic [BW-1:0]     bcnt;
  logic [7:0]        csum;
  logic [DATA_W-1:0] shreg;
  logic [TW-1:0]     tcnt;

  logic [DATA_W+7:0] shcat;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        csum_nxt;
  logic              in_frame;
  logic              last_byte;
  logic              timeout_hit;

  // Byte shift (new byte enters at the top so the first byte ends at [7:0]) and status decode
  always_comb begin
    shcat       = {rx_byte_i, shreg};
    shifted     = shcat[DATA_W+7:8];
    csum_nxt    = csum + rx_byte_i;
    in_frame    = (state == StLen0) || (state == StLen1) || (state == StData) ||
                  (state == StCsum);
    last_byte   = (bcnt == BW'(NBYTES - 1));
    timeout_hit = (TIMEOUT_CYC != 0) && in_frame && !rx_dv_i &&
                  (tcnt == TW'(TIMEOUT_CYC - 1));
  end

  // Loader FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      we_o        <= 1'b0;
      addr_o      <= BASE_ADDR;
      wdata_o     <= '0;
      core_rst_no <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
      len_lo      <= '0;
      len         <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      csum        <= '0;
      shreg       <= '0;
      tcnt        <= '0;
    end else begin
      we_o <= 1'b0;
      // Address and word count advance in the cycle after each write pulse
      if (we_o) begin
        addr_o  <= addr_o + 1'b1;
        words_o <= words_o + 16'd1;
      end

      if (rx_dv_i) tcnt <= '0;
      else if (in_frame) tcnt <= tcnt + 1'b1;

      if (reload_i) begin
        // Reload wins over a simultaneous byte, which is dropped
        state       <= StIdle;
        core_rst_no <= 1'b0;
        done_o      <= 1'b0;
        busy_o      <= 1'b0;
      end else if (timeout_hit) begin
        state  <= StIdle;
        err_o  <= 1'b1;
        busy_o <= 1'b0;
      end else if (rx_dv_i) begin
        case (state)
          StIdle: begin
            if (rx_byte_i == SYNC_BYTE) begin
              state   <= StLen0;
              err_o   <= 1'b0;
              done_o  <= 1'b0;
              words_o <= '0;
              csum    <= '0;
              addr_o  <= BASE_ADDR;
              busy_o  <= 1'b1;
            end
          end
          StLen0: begin
            len_lo <= rx_byte_i;
            csum   <= csum_nxt;
            state  <= StLen1;
          end
          StLen1: begin
            len   <= {rx_byte_i, len_lo};
            csum  <= csum_nxt;
            bcnt  <= '0;
            wcnt  <= '0;
            state <= ({rx_byte_i, len_lo} == 16'd0) ? StCsum : StData;
          end
          StData: begin
            csum  <= csum_nxt;
            shreg <= shifted;
            if (last_byte) begin
              wdata_o <= shifted;
              we_o    <= 1'b1;
              bcnt    <= '0;
              wcnt    <= wcnt + 16'd1;
              if (wcnt + 16'd1 == len) state <= StCsum;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          StCsum: begin
            busy_o <= 1'b0;
            if (csum_nxt == 8'h00) begin
              state       <= StRun;
              done_o      <= 1'b1;
              core_rst_no <= 1'b1;
            end else begin
              state <= StIdle;
              err_o <= 1'b1;
            end
          end
          default: ;  // StRun ignores all received bytes
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed bench for ram_prog_loader: a 32-bit instance with a short timeout
// and an 8-bit instance with a tiny wrapping address space.
module tb_ram_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=32, ADDR_W=14, BASE_ADDR=0, TIMEOUT_CYC=16
  logic        rst_a = 1'b1, dv_a = 1'b0, rl_a = 1'b0;
  logic [7:0]  byte_a = '0;
  logic        we_a, crn_a, busy_a, done_a, err_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;
  logic [15:0] words_a;

  // Instance B: DATA_W=8, ADDR_W=2, BASE_ADDR=3
  logic        rst_b = 1'b1, dv_b = 1'b0, rl_b = 1'b0;
  logic [7:0]  byte_b = '0;
  logic        we_b, crn_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [7:0]  wdata_b;
  logic [15:0] words_b;

  ram_prog_loader #(
    .DATA_W(32), .ADDR_W(14), .BASE_ADDR(14'd0), .SYNC_BYTE(8'h55), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .rx_dv_i(dv_a), .rx_byte_i(byte_a), .reload_i(rl_a),
    .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a), .core_rst_no(crn_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .words_o(words_a)
  );

  ram_prog_loader #(
    .DATA_W(8), .ADDR_W(2), .BASE_ADDR(2'd3), .SYNC_BYTE(8'h55), .TIMEOUT_CYC(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .rx_dv_i(dv_b), .rx_byte_i(byte_b), .reload_i(rl_b),
    .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b), .core_rst_no(crn_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .words_o(words_b)
  );

  int nvec = 0;
  int nerr = 0;
  int nwr_a = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Count write pulses and make sure none happen while the core runs
  always @(negedge clk) begin
    if (!rst_a) begin
      if (we_a) nwr_a++;
      check("we_while_run_a", {63'd0, we_a & crn_a}, 64'd0);
    end
  end

  task automatic send_a(input logic [7:0] b);
    dv_a = 1'b1; byte_a = b;
    @(posedge clk); #1;
    dv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    dv_b = 1'b1; byte_b = b;
    @(posedge clk); #1;
    dv_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reload_a();
    rl_a = 1'b1;
    @(posedge clk); #1;
    rl_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_we"},    {63'd0, we_a},    64'd0);
    check({tag, "_addr"},  {50'd0, addr_a},  64'd0);
    check({tag, "_wdata"}, {32'd0, wdata_a}, 64'd0);
    check({tag, "_crn"},   {63'd0, crn_a},   64'd0);
    check({tag, "_busy"},  {63'd0, busy_a},  64'd0);
    check({tag, "_done"},  {63'd0, done_a},  64'd0);
    check({tag, "_err"},   {63'd0, err_a},   64'd0);
    check({tag, "_words"}, {48'd0, words_a}, 64'd0);
  endtask

  logic [7:0] good [12] = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                            8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
  logic [7:0] bad  [12] = '{8'h55, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                            8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};

  initial begin
    idle(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_reset_a("rst");

    // Good two-word frame with per-byte timing checks
    send_a(8'h55);
    check("sync_busy", {63'd0, busy_a}, 64'd1);
    send_a(8'h02); send_a(8'h00); send_a(8'h11); send_a(8'h22); send_a(8'h33);
    check("w0_we", {63'd0, we_a}, 64'd0);
    send_a(8'h44);
    check("w0_we", {63'd0, we_a}, 64'd1);
    check("w0_addr", {50'd0, addr_a}, 64'd0);
    check("w0_data", {32'd0, wdata_a}, 64'h44332211);
    send_a(8'hAA);
    check("w0_pulse_len", {63'd0, we_a}, 64'd0);
    check("addr_adv", {50'd0, addr_a}, 64'd1);
    send_a(8'hBB); send_a(8'hCC); send_a(8'hDD);
    check("w1_we", {63'd0, we_a}, 64'd1);
    check("w1_addr", {50'd0, addr_a}, 64'd1);
    check("w1_data", {32'd0, wdata_a}, 64'hDDCCBBAA);
    send_a(8'h46);
    check("ok_done", {63'd0, done_a}, 64'd1);
    check("ok_crn", {63'd0, crn_a}, 64'd1);
    check("ok_busy", {63'd0, busy_a}, 64'd0);
    check("ok_err", {63'd0, err_a}, 64'd0);
    check("ok_words", {48'd0, words_a}, 64'd2);
    check("ok_nwr", nwr_a, 64'd2);

    // RUN ignores a sync byte
    send_a(8'h55);
    check("run_ign_busy", {63'd0, busy_a}, 64'd0);

    // Reload keeps words, clears done, drops core reset
    reload_a();
    check("rl_crn", {63'd0, crn_a}, 64'd0);
    check("rl_done", {63'd0, done_a}, 64'd0);
    check("rl_words", {48'd0, words_a}, 64'd2);

    // Bad checksum: writes still happen, then error
    for (int i = 0; i < 12; i++) send_a(bad[i]);
    check("bad_err", {63'd0, err_a}, 64'd1);
    check("bad_crn", {63'd0, crn_a}, 64'd0);
    check("bad_busy", {63'd0, busy_a}, 64'd0);
    check("bad_done", {63'd0, done_a}, 64'd0);
    check("bad_nwr", nwr_a, 64'd4);

    // Following good frame clears the error
    for (int i = 0; i < 12; i++) send_a(good[i]);
    check("rec_done", {63'd0, done_a}, 64'd1);
    check("rec_err", {63'd0, err_a}, 64'd0);
    check("rec_crn", {63'd0, crn_a}, 64'd1);
    check("rec_nwr", nwr_a, 64'd6);
    reload_a();

    // Timeout on a partial word: 16 idle cycles after the last byte
    send_a(8'h55); send_a(8'h01); send_a(8'h00); send_a(8'h11); send_a(8'h22);
    check("to_busy", {63'd0, busy_a}, 64'd1);
    idle(15);
    check("to_early_busy", {63'd0, busy_a}, 64'd1);
    check("to_early_err", {63'd0, err_a}, 64'd0);
    idle(1);
    check("to_err", {63'd0, err_a}, 64'd1);
    check("to_busy_low", {63'd0, busy_a}, 64'd0);
    check("to_nwr", nwr_a, 64'd6);
    send_a(8'h55);
    check("to_resync_busy", {63'd0, busy_a}, 64'd1);
    check("to_resync_err", {63'd0, err_a}, 64'd0);

    // Zero-length frame, then reload colliding with an rx strobe
    send_a(8'h00); send_a(8'h00); send_a(8'h00);
    check("z_done", {63'd0, done_a}, 64'd1);
    check("z_crn", {63'd0, crn_a}, 64'd1);
    check("z_nwr", nwr_a, 64'd6);
    rl_a = 1'b1; dv_a = 1'b1; byte_a = 8'h55;
    @(posedge clk); #1;
    rl_a = 1'b0; dv_a = 1'b0;
    check("rlc_crn", {63'd0, crn_a}, 64'd0);
    check("rlc_idle", {63'd0, busy_a}, 64'd0);
    check("rlc_done", {63'd0, done_a}, 64'd0);

    // Reset in the middle of DATA
    send_a(8'h55); send_a(8'h02); send_a(8'h00); send_a(8'h11); send_a(8'h22);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check_reset_a("mid_rst");
    send_a(8'h33); send_a(8'h44);
    idle(1);
    check("mid_rst_nwr", nwr_a, 64'd6);
    check("mid_rst_busy", {63'd0, busy_a}, 64'd0);

    // 8-bit words with address wrap from BASE_ADDR=3
    check("b_rst_addr", {62'd0, addr_b}, 64'd3);
    send_b(8'h55); send_b(8'h03); send_b(8'h00);
    send_b(8'hA1);
    check("b_w0_we", {63'd0, we_b}, 64'd1);
    check("b_w0_addr", {62'd0, addr_b}, 64'd3);
    check("b_w0_data", {56'd0, wdata_b}, 64'hA1);
    send_b(8'hB2);
    check("b_w1_we", {63'd0, we_b}, 64'd1);
    check("b_w1_addr", {62'd0, addr_b}, 64'd0);
    check("b_w1_data", {56'd0, wdata_b}, 64'hB2);
    send_b(8'hC3);
    check("b_w2_we", {63'd0, we_b}, 64'd1);
    check("b_w2_addr", {62'd0, addr_b}, 64'd1);
    check("b_w2_data", {56'd0, wdata_b}, 64'hC3);
    send_b(8'hE7);
    check("b_done", {63'd0, done_b}, 64'd1);
    check("b_crn", {63'd0, crn_b}, 64'd1);
    check("b_err", {63'd0, err_b}, 64'd0);
    check("b_words", {48'd0, words_b}, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
